// File: rtl/bin_to_rns_9_8_7_if.sv
// Handshake bundle between a binary producer, the bin_to_rns_9_8_7
// converter and its residue consumer.
// Optional macro RNS_CONV_RANGE_CHK_EN adds the out_ovf range flag.
interface bin_to_rns_9_8_7_if #(
   parameter int IN_W = 9
);
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] bin;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      x1;
   logic [2:0]      x2;
   logic [2:0]      x3;
`ifdef RNS_CONV_RANGE_CHK_EN
   logic            out_ovf;
`endif

   // Producer/consumer side: drives the operand and accepts residues.
   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, x1, x2, x3
`ifdef RNS_CONV_RANGE_CHK_EN
      , input out_ovf
`endif
   );

   // Converter side.
   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, x1, x2, x3
`ifdef RNS_CONV_RANGE_CHK_EN
      , output out_ovf
`endif
   );
endinterface

// File: rtl/bin_to_rns_9_8_7.sv
// Bit-serial binary to RNS (9, 8, 7) forward converter.
// Horner reduction, MSB first, one bit per clock; valid/ready on both sides.
// Optional macro RNS_CONV_RANGE_CHK_EN: out_ovf flags inputs >= 504.
module bin_to_rns_9_8_7 #(
   parameter int IN_W = 9
) (
   input logic               clk,
   input logic               rst_n,
   bin_to_rns_9_8_7_if.slave bus
);
   localparam int CNT_W = $clog2(IN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state, next_state;
   logic [IN_W-1:0]   sreg;
   logic [CNT_W-1:0]  cnt;
   logic [4:0]        r9;
   logic [2:0]        r8;
   logic [3:0]        r7;
   logic              in_ready, out_valid;

   // 2r + b stays <= 17 because r <= 8, so a single subtract reduces it.
   function automatic logic [4:0] step9(input logic [4:0] r, input logic b);
      logic [4:0] t;
      t = 5'({r, b});
      return (t >= 5'd9) ? t - 5'd9 : t;
   endfunction

   // Modulo 8 is just the low three bits of 2r + b.
   function automatic logic [2:0] step8(input logic [2:0] r, input logic b);
      return 3'({r, b});
   endfunction

   // 2r + b stays <= 13 because r <= 6, so a single subtract reduces it.
   function automatic logic [3:0] step7(input logic [3:0] r, input logic b);
      logic [3:0] t;
      t = 4'({r, b});
      return (t >= 4'd7) ? t - 4'd7 : t;
   endfunction

   // State register; reset aborts any conversion or held result.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state decode and handshake outputs decoded from state.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) next_state = SHIFT;
         end
         SHIFT: begin
            if (cnt == CNT_W'(1)) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand capture and one Horner step per SHIFT cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
         r9   <= '0;
         r8   <= '0;
         r7   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sreg <= bus.bin;
                  cnt  <= CNT_W'(IN_W);
                  r9   <= '0;
                  r8   <= '0;
                  r7   <= '0;
               end
            end
            SHIFT: begin
               sreg <= sreg << 1;
               cnt  <= cnt - CNT_W'(1);
               r9   <= step9(r9, sreg[IN_W-1]);
               r8   <= step8(r8, sreg[IN_W-1]);
               r7   <= step7(r7, sreg[IN_W-1]);
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   // Residues are fully reduced, so dropping the top bit is lossless.
   assign bus.x1 = 4'(r9);
   assign bus.x2 = r8;
   assign bus.x3 = 3'(r7);

`ifdef RNS_CONV_RANGE_CHK_EN
   logic flag;

   // Range flag captured alongside the operand; always 0 when IN_W < 9.
   always_ff @(posedge clk) begin
      if (!rst_n)
         flag <= 1'b0;
      else if (state == IDLE && bus.in_valid)
         flag <= (32'(bus.bin) >= 32'd504);
   end

   assign bus.out_ovf = (state == DONE) && flag;
`endif
endmodule

// File: doc/bin_to_rns_9_8_7.md
Name: bin_to_rns_9_8_7

Overview:
Sequential forward converter from binary to RNS with moduli (9, 8, 7), dynamic range 504. It sits directly upstream of compare_const_10_9_8_7 and drives its residue inputs x1 (mod 9), x2 (mod 8) and x3 (mod 7). The conversion is bit-serial Horner reduction, MSB first, one input bit per clock. Input and output each use a valid/ready handshake.

Parameters:
IN_W, 9, input binary width; legal range 1..16; the default covers 0..511.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge
in_valid  input  1  bin is valid
in_ready  output  1  converter idle; it can accept bin
bin  input  IN_W  unsigned binary operand
out_valid  output  1  residues are valid
out_ready  input  1  consumer accepts the residues
x1  output  4  bin mod 9, range 0..8
x2  output  3  bin mod 8, range 0..7
x3  output  3  bin mod 7, range 0..6
out_ovf  output  1  only present with RNS_CONV_RANGE_CHK_EN; high when bin >= 504

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following values apply.
  - state = IDLE, in_ready = 1, out_valid = 0.
  - x1 = x2 = x3 = 0, out_ovf = 0.
  - Bit counter and shift register are cleared.
- Reset overrides everything, including a conversion in progress and a held output. Any in-flight conversion is discarded.
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1 (decoded from state), out_valid = 0.
  - On an edge with in_valid=1: load bin into the shift register, clear r9/r8/r7, set cnt = IN_W, go to SHIFT.
- SHIFT:
  - in_ready = 0, out_valid = 0.
  - Each edge consumes the MSB b of the shift register, shifts it left and decrements cnt.
  - r9 <= (2*r9 + b) >= 9 ? 2*r9 + b - 9 : 2*r9 + b. The maximum intermediate value is 17, so one conditional subtract is sufficient.
  - r8 <= (2*r8 + b) mod 8, i.e. the low 3 bits.
  - r7 <= (2*r7 + b) >= 7 ? 2*r7 + b - 7 : 2*r7 + b. The maximum intermediate value is 13.
  - On the edge where cnt goes 1 -> 0, go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - x1/x2/x3 = r9/r8/r7, held stable while out_ready = 0 (for any number of cycles).
  - On an edge with out_ready=1, go to IDLE.
- Latency and throughput:
  - out_valid rises exactly IN_W cycles after the accepting edge (9 cycles by default).
  - Minimum period between accepts is IN_W + 2 cycles; there is no overlap of consecutive operations.
- in_valid while the converter is not in IDLE is ignored. Input is never captured outside IDLE.
- bin must be stable only on the accepting edge.
- Out-of-range values: inputs 504..511 are not rejected. The residues are the true residues of bin, which alias onto bin - 504 (e.g. 511 -> (7,7,0)).
- x1/x2/x3 may change while out_valid=0. The consumer must qualify them with out_valid.
- Arithmetic width: internal r9 is 5 bits, r8 is 3 bits, r7 is 4 bits. Outputs are truncated to the port widths, which is lossless after reduction.

Optional Feature:
Macro: RNS_CONV_RANGE_CHK_EN
- Defined:
  - out_ovf port exists.
  - On the accepting edge, a flag register captures (bin >= 504).
  - out_ovf = flag while in DONE and 0 otherwise. It resets to 0.
  - Residues are computed unchanged.
  - For IN_W < 9 the flag is constant 0.
- Undefined: no out_ovf port and no comparator logic. Behaviour is otherwise identical.

Test Plan:
1. Reset, then bin=10 with in_valid pulsed for 1 cycle and out_ready=1 -> out_valid rises 9 cycles after accept with (x1,x2,x3)=(1,2,3). in_ready returns to 1 one cycle after the output handshake.
2. Boundary values -> bin=0 gives (0,0,0); bin=503 gives (8,7,6); bin=511 gives (7,7,0). With RNS_CONV_RANGE_CHK_EN: out_ovf=0 for 0 and 503, out_ovf=1 for 511 and 504; 504 gives residues (0,0,0).
3. Backpressure: bin=257 with out_ready held at 0 for 20 cycles -> out_valid stays 1 and outputs stay (5,1,5). A new in_valid=1 with bin=3 during this time is ignored. When out_ready=1 the handshake completes and the following result is for bin=3 only after re-acceptance.
4. Reset mid-operation: accept bin=100, then drive rst_n=0 for 1 cycle at accept+4 -> next cycle shows in_ready=1 and out_valid=0. A fresh bin=10 then converts to (1,2,3) with nothing left over from the aborted operation.
5. Exhaustive chain: feed bin=0..503 with random out_ready stalls into compare_const_10_9_8_7 -> residues equal (i%9, i%8, i%7). The comparator reports le for i<10, eq for i=10 and gr for i>10, with no mismatches.
